// File: rtl/npc_isa_pkg.sv
// RV32I decode constants shared by the instruction decode unit.
package npc_isa_pkg;

   // Instruction format as seen by the EXU; FMT_R is the cleared value.
   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } inst_fmt_t;

   // Holding register occupancy.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } idu_state_t;

   // RV32I base opcodes.
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // Bit offsets of the fields inside the 64-bit fetch packet.
   localparam int INST_LSB = 32;
   localparam int PC_LSB   = 0;

   // Map a 7-bit opcode to its format; anything outside the base set is illegal.
   // Every legal opcode ends in 2'b11, so a bad inst[1:0] also lands in FMT_ILL.
   function automatic inst_fmt_t opc_to_fmt(input logic [6:0] opc);
      inst_fmt_t fmt;
      case (opc)
         OPC_OP:                                     fmt = FMT_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
         OPC_STORE:                                  fmt = FMT_S;
         OPC_BRANCH:                                 fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
         OPC_JAL:                                    fmt = FMT_J;
         default:                                    fmt = FMT_ILL;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// Combinational RV32I immediate generator. Only the bits above the opcode
// carry immediate information, so the opcode field is not an input here.
module idu_imm_gen
   import npc_isa_pkg::*;
(
   input  logic [31:7] inst,
   input  inst_fmt_t   fmt,
   output logic [31:0] imm
);

   // Reassemble and sign-extend the immediate for the given format.
   always_comb begin
      imm = 32'd0;
      case (fmt)
         FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm = {inst[31:12], 12'd0};
         FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/idu_decode_stage.sv
// IDU decode stage: one-entry registered buffer between the IFU and EXU
// valid/ready links, decoding each RV32I fetch packet as it is captured.
module idu_decode_stage
   import npc_isa_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifu_valid,
   input  logic [63:0]      ifu_data,
   output logic             idu_ready,
   input  logic             flush,
   output logic             exu_valid,
   input  logic             exu_ready,
   output logic [WIDTH-1:0] exu_pc,
   output logic [31:0]      exu_inst,
   output logic [4:0]       exu_rd,
   output logic [4:0]       exu_rs1,
   output logic [4:0]       exu_rs2,
   output logic [31:0]      exu_imm,
   output inst_fmt_t        exu_fmt,
   output logic             exu_wen,
   output logic             exu_illegal
);

   idu_state_t       state_q, state_d;
   logic             accept;

   logic [31:0]      inst_p0;
   logic [WIDTH-1:0] pc_p0;
   inst_fmt_t        fmt_p0;
   logic [31:0]      imm_p0;
   logic             wen_p0;

   logic [WIDTH-1:0] pc_p1;
   logic [31:0]      inst_p1;
   logic [31:0]      imm_p1;
   inst_fmt_t        fmt_p1;
   logic             wen_p1;

   // A slot is free when empty or when the EXU drains it this cycle; flush blocks intake.
   assign idu_ready = !flush && ((state_q == ST_EMPTY) || exu_ready);
   assign accept    = ifu_valid && idu_ready;

   // ---- p0: combinational decode of the incoming packet ----
   assign inst_p0 = ifu_data[INST_LSB +: 32];
   assign pc_p0   = ifu_data[PC_LSB +: WIDTH];
   assign fmt_p0  = opc_to_fmt(inst_p0[6:0]);
   assign wen_p0  = ((fmt_p0 == FMT_R) || (fmt_p0 == FMT_I) ||
                     (fmt_p0 == FMT_U) || (fmt_p0 == FMT_J)) && (inst_p0[11:7] != 5'd0);

   idu_imm_gen u_imm_gen (
      .inst (inst_p0[31:7]),
      .fmt  (fmt_p0),
      .imm  (imm_p0)
   );

   // Occupancy register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
   end

   // Next occupancy: flush empties; a new accept fills; a drain without refill empties.
   always_comb begin
      state_d = state_q;
      if (flush)          state_d = ST_EMPTY;
      else if (accept)    state_d = ST_FULL;
      else if (exu_ready) state_d = ST_EMPTY;
   end

   // ---- p1: registered bundle presented to the EXU ----
   // Capture the decoded bundle only on accept so it stays stable under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_p1   <= '0;
         inst_p1 <= '0;
         imm_p1  <= '0;
         fmt_p1  <= FMT_R;
         wen_p1  <= 1'b0;
      end else if (accept) begin
         pc_p1   <= pc_p0;
         inst_p1 <= inst_p0;
         imm_p1  <= imm_p0;
         fmt_p1  <= fmt_p0;
         wen_p1  <= wen_p0;
      end
   end

   assign exu_valid   = (state_q == ST_FULL);
   assign exu_pc      = pc_p1;
   assign exu_inst    = inst_p1;
   assign exu_rd      = inst_p1[11:7];
   assign exu_rs1     = inst_p1[19:15];
   assign exu_rs2     = inst_p1[24:20];
   assign exu_imm     = imm_p1;
   assign exu_fmt     = fmt_p1;
   assign exu_wen     = wen_p1;
   assign exu_illegal = (fmt_p1 == FMT_ILL);

endmodule

// File: tb/tb_idu_decode_stage.sv
// Scoreboard bench for idu_decode_stage: stimulus pushes hand-computed
// bundles on accept, a negedge monitor pops and compares on each handshake.
module tb_idu_decode_stage;
   import npc_isa_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        wen;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_valid;
   logic [63:0] ifu_data;
   logic        idu_ready;
   logic        flush;
   logic        exu_valid;
   logic        exu_ready;
   logic [31:0] exu_pc;
   logic [31:0] exu_inst;
   logic [4:0]  exu_rd;
   logic [4:0]  exu_rs1;
   logic [4:0]  exu_rs2;
   logic [31:0] exu_imm;
   inst_fmt_t   exu_fmt;
   logic        exu_wen;
   logic        exu_illegal;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   exp_t prev_snap;
   logic prev_stall = 1'b0;

   always #5 clk = ~clk;

   idu_decode_stage #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .ifu_valid   (ifu_valid),
      .ifu_data    (ifu_data),
      .idu_ready   (idu_ready),
      .flush       (flush),
      .exu_valid   (exu_valid),
      .exu_ready   (exu_ready),
      .exu_pc      (exu_pc),
      .exu_inst    (exu_inst),
      .exu_rd      (exu_rd),
      .exu_rs1     (exu_rs1),
      .exu_rs2     (exu_rs2),
      .exu_imm     (exu_imm),
      .exu_fmt     (exu_fmt),
      .exu_wen     (exu_wen),
      .exu_illegal (exu_illegal)
   );

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [2:0] fmt,
                               input logic wen, input logic ill);
      exp_t e;
      e.pc = pc; e.inst = inst; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      e.imm = imm; e.fmt = fmt; e.wen = wen; e.ill = ill;
      return e;
   endfunction

   function automatic exp_t cur_bundle();
      return mk(exu_pc, exu_inst, exu_rd, exu_rs1, exu_rs2, exu_imm, exu_fmt, exu_wen, exu_illegal);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Present a packet until accepted; the expected bundle is queued at acceptance.
   task automatic send(input exp_t e);
      int n;
      ifu_valid = 1'b1;
      ifu_data  = {e.inst, e.pc};
      n = 0;
      while (1) begin
         @(negedge clk);
         if (idu_ready) begin
            sb.push_back(e);
            break;
         end
         n++;
         if (n > 50) begin
            chk("accept_timeout", 128'd0, 128'd1);
            break;
         end
      end
      @(posedge clk); #1;
      ifu_valid = 1'b0;
   endtask

   // Monitor: compare on every completed handshake; check stability across stalls.
   always @(negedge clk) begin
      if (rst) begin
         if (prev_stall && exu_valid) chk("stall_stable", cur_bundle(), prev_snap);
         if (exu_valid && exu_ready && !flush) begin
            if (sb.size() == 0) chk("unexpected_bundle", cur_bundle(), 128'd0);
            else chk("bundle", cur_bundle(), sb.pop_front());
         end
         prev_stall = exu_valid && !exu_ready && !flush;
         prev_snap  = cur_bundle();
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; ifu_valid = 1'b0; ifu_data = '0; flush = 1'b0; exu_ready = 1'b1;
      #3;
      chk("reset_valid", exu_valid, 0);
      chk("reset_pc", exu_pc, 0);
      chk("reset_fmt", exu_fmt, FMT_R);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      chk("post_reset_ready", idu_ready, 1);

      // Single beat with latency 1.
      send(mk(32'h8000_0000, 32'h0050_0093, 5'd1, 5'd0, 5'd5, 32'd5, FMT_I, 1'b1, 1'b0));
      chk("latency1_valid", exu_valid, 1);

      // Back-to-back formats, including illegal packets mid-stream.
      send(mk(32'h8000_0004, 32'h1234_5137, 5'd2, 5'd8, 5'd3, 32'h1234_5000, FMT_U, 1'b1, 1'b0));
      send(mk(32'h8000_0008, 32'hFE11_2E23, 5'd28, 5'd2, 5'd1, 32'hFFFF_FFFC, FMT_S, 1'b0, 1'b0));
      send(mk(32'h8000_000C, 32'hFE00_0CE3, 5'd25, 5'd0, 5'd0, 32'hFFFF_FFF8, FMT_B, 1'b0, 1'b0));
      send(mk(32'h8000_0010, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 32'd0, FMT_ILL, 1'b0, 1'b1));
      send(mk(32'h8000_0014, 32'h0080_00EF, 5'd1, 5'd0, 5'd8, 32'd8, FMT_J, 1'b1, 1'b0));
      send(mk(32'h8000_0018, 32'h0020_81B3, 5'd3, 5'd1, 5'd2, 32'd0, FMT_R, 1'b1, 1'b0));
      send(mk(32'h8000_001C, 32'h0050_0091, 5'd1, 5'd0, 5'd5, 32'd0, FMT_ILL, 1'b0, 1'b1));
      send(mk(32'h8000_0020, 32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'd0, FMT_I, 1'b0, 1'b0));

      // Backpressure: three packets, EXU stalled for 4 cycles after the first accept.
      @(posedge clk); #1;
      exu_ready = 1'b0;
      send(mk(32'h8000_0100, 32'h0010_0113, 5'd2, 5'd0, 5'd1, 32'd1, FMT_I, 1'b1, 1'b0));
      fork
         begin
            send(mk(32'h8000_0104, 32'h0020_8193, 5'd3, 5'd1, 5'd2, 32'd2, FMT_I, 1'b1, 1'b0));
            send(mk(32'h8000_0108, 32'hFFF0_0213, 5'd4, 5'd0, 5'd31, 32'hFFFF_FFFF, FMT_I, 1'b1, 1'b0));
         end
         begin
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               chk("stall_ready_low", idu_ready, 0);
            end
            @(posedge clk); #1;
            exu_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("drain_b2b_valid", exu_valid, 1);
            end
            @(negedge clk);
            chk("drain_done_valid", exu_valid, 0);
         end
      join

      // Flush while FULL and stalled, with a competing input packet.
      @(posedge clk); #1;
      exu_ready = 1'b0;
      send(mk(32'h8000_0200, 32'h0050_0093, 5'd1, 5'd0, 5'd5, 32'd5, FMT_I, 1'b1, 1'b0));
      flush = 1'b1; ifu_valid = 1'b1; ifu_data = {32'h0020_81B3, 32'h8000_0204};
      @(negedge clk);
      chk("flush_ready_low", idu_ready, 0);
      void'(sb.pop_front());
      @(posedge clk); #1;
      flush = 1'b0; ifu_valid = 1'b0;
      chk("flush_valid_low", exu_valid, 0);
      exu_ready = 1'b1;
      send(mk(32'h8000_0208, 32'h1234_5137, 5'd2, 5'd8, 5'd3, 32'h1234_5000, FMT_U, 1'b1, 1'b0));

      // Asynchronous reset mid-cycle while FULL.
      @(posedge clk); #1;
      exu_ready = 1'b0;
      send(mk(32'h8000_0300, 32'hFE11_2E23, 5'd28, 5'd2, 5'd1, 32'hFFFF_FFFC, FMT_S, 1'b0, 1'b0));
      #1 rst = 1'b0;
      #1;
      chk("async_rst_valid", exu_valid, 0);
      chk("async_rst_pc", exu_pc, 0);
      chk("async_rst_fmt", exu_fmt, FMT_R);
      void'(sb.pop_front());
      @(posedge clk); #1;
      rst = 1'b1;
      chk("rst_release_ready", idu_ready, 1);
      chk("rst_release_valid", exu_valid, 0);
      exu_ready = 1'b1;
      send(mk(32'h8000_0400, 32'hFE00_0CE3, 5'd25, 5'd0, 5'd0, 32'hFFFF_FFF8, FMT_B, 1'b0, 1'b0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
